// File: rtl/uart_tx_sched.sv
// Byte FIFO in front of a UART transmitter: buffers processor writes and issues
// one-cycle write strobes to the UART, pacing them on the UART busy handshake.
module uart_tx_sched #(
  parameter int DEPTH_LOG2   = 3,
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ip_wr,
  input  logic [7:0]            ip_tx_data,
  output logic                  op_full,
  output logic                  op_empty,
  output logic [DEPTH_LOG2:0]   op_count,
  output logic                  op_overflow,
  input  logic                  ip_clr_overflow,
  output logic                  op_uart_wr,
  output logic [7:0]            op_uart_tx_data,
  input  logic                  ip_uart_busy
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int TW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TW-1:0]       TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  full_reg, empty_reg;
  logic                  overflow_reg, overflow_next;
  state_t                state_reg, state_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic                  pop, push, drop;

  // Scheduler: a strobe pops the head; then wait for busy to rise (bounded) and fall.
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_reg && !ip_uart_busy && !reset) begin
          pop        = 1'b1;
          state_next = WAIT_BUSY;
          timer_next = '0;
        end
      end
      WAIT_BUSY: begin
        if (ip_uart_busy) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == TIMER_LAST) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!ip_uart_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push = ip_wr && (!full_reg || pop);
    drop = ip_wr && full_reg && !pop;
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (ip_clr_overflow) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      wr_ptr_reg   <= push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
      rd_ptr_reg   <= pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
      count_reg    <= count_next;
      full_reg     <= (count_next == DEPTH_CNT);
      empty_reg    <= (count_next == '0);
      overflow_reg <= overflow_next;
    end
  end

  // Storage is deliberately not reset; the head is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr_reg] <= ip_tx_data;
    end
  end

  assign op_uart_wr      = pop;
  assign op_uart_tx_data = mem[rd_ptr_reg];
  assign op_count        = count_reg;
  assign op_full         = full_reg;
  assign op_empty        = empty_reg;
  assign op_overflow     = overflow_reg;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: fixed vector table, directed corner sequences and a
// randomized run checked every cycle against a queue-based reference model.
module tb_uart_tx_sched;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 8;
  localparam int BT         = 3;

  logic       clk = 1'b0;
  logic       reset, ip_wr, ip_clr_overflow, ip_uart_busy;
  logic [7:0] ip_tx_data;
  logic       op_full, op_empty, op_overflow, op_uart_wr;
  logic [3:0] op_count;
  logic [7:0] op_uart_tx_data;

  always #5 clk = ~clk;

  uart_tx_sched #(.DEPTH_LOG2(DEPTH_LOG2), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset), .ip_wr(ip_wr), .ip_tx_data(ip_tx_data),
    .op_full(op_full), .op_empty(op_empty), .op_count(op_count),
    .op_overflow(op_overflow), .ip_clr_overflow(ip_clr_overflow),
    .op_uart_wr(op_uart_wr), .op_uart_tx_data(op_uart_tx_data),
    .ip_uart_busy(ip_uart_busy)
  );

  int total = 0;
  int bad   = 0;

  // stimulus for the current cycle
  logic       s_wr = 0, s_busy = 0, s_clr = 0, s_rst = 0;
  logic [7:0] s_data = 0;

  // UART model: busy rises the cycle after a strobe and lasts uart_len cycles
  bit use_uart = 0;
  int uart_len = 10;
  int ignore_pct = 0;
  int uart_left = 0;

  // reference model
  logic [7:0] mq[$];
  bit m_ovf = 0, m_free = 1, m_seen = 0, model_ok = 0, exp_wr = 0;
  int m_elapsed = 0;

  logic [7:0] tx_log[$];
  bit saw_full = 0;

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic       ew;
    logic [7:0] ed;
    logic [3:0] ec;
  } vec_t;
  vec_t tv[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_and_sample();
    if (use_uart) s_busy = (uart_left > 0);
    reset = s_rst; ip_wr = s_wr; ip_tx_data = s_data;
    ip_clr_overflow = s_clr; ip_uart_busy = s_busy;
    #1;
    exp_wr = model_ok && !s_rst && m_free && (mq.size() > 0) && !s_busy;
    if (model_ok) begin
      chk("strobe", op_uart_wr, exp_wr);
      chk("count", op_count, mq.size());
      chk("full", op_full, mq.size() == DEPTH);
      chk("empty", op_empty, mq.size() == 0);
      chk("overflow", op_overflow, m_ovf);
      if (mq.size() > 0) chk("head", op_uart_tx_data, mq[0]);
    end
    if (op_full === 1'b1) saw_full = 1;
    if (op_uart_wr === 1'b1) begin
      tx_log.push_back(op_uart_tx_data);
      $display("tx byte %02h at %0t", op_uart_tx_data, $time);
    end
  endtask

  task automatic finish_cycle();
    int sz;
    bit pop, pushok, drop;
    @(posedge clk);
    if (s_rst) begin
      mq.delete();
      m_ovf = 0; m_free = 1; m_seen = 0; m_elapsed = 0; model_ok = 1;
    end else if (model_ok) begin
      sz = mq.size();
      pop = exp_wr;
      if (pop) void'(mq.pop_front());
      pushok = s_wr && ((sz < DEPTH) || pop);
      drop = s_wr && !pushok;
      if (pushok) mq.push_back(s_data);
      if (drop) m_ovf = 1;
      else if (s_clr) m_ovf = 0;
      // after a strobe: free again once busy has risen and fallen, or BT cycles without busy
      if (pop) begin
        m_free = 0; m_elapsed = 0; m_seen = 0;
      end else if (!m_free) begin
        if (!m_seen) begin
          m_elapsed++;
          if (s_busy) m_seen = 1;
          else if (m_elapsed == BT) m_free = 1;
        end else if (!s_busy) begin
          m_free = 1;
        end
      end
    end
    if (uart_left > 0) uart_left--;
    if (use_uart && exp_wr && ($urandom_range(99) >= ignore_pct)) uart_left = uart_len;
    @(negedge clk);
  endtask

  task automatic step();
    drive_and_sample();
    finish_cycle();
  endtask

  initial begin
    int n;
    logic [7:0] exp_seq[9];

    //        wr    d      busy  ew    ed     count
    tv[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 4'd0};
    tv[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 4'd1};
    tv[2]  = '{1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 4'd0};
    tv[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd1};
    tv[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd1};
    tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 4'd1};
    tv[6]  = '{1'b1, 8'h43, 1'b1, 1'b0, 8'h00, 4'd0};
    tv[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd1};
    tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h43, 4'd1};
    tv[9]  = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 4'd0};
    tv[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd1};
    tv[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd1};
    tv[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd1};
    tv[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 4'd1};
    tv[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 4'd0};

    // reset state
    s_rst = 1; step(); step(); s_rst = 0;
    chk("rst_count", op_count, 0);
    chk("rst_empty", op_empty, 1);
    chk("rst_full", op_full, 0);
    chk("rst_ovf", op_overflow, 0);
    chk("rst_wr", op_uart_wr, 0);

    // single byte, lost strobe timeout, minimum spacing, busy blocking
    for (int i = 0; i < 15; i++) begin
      s_wr = tv[i].wr; s_data = tv[i].d; s_busy = tv[i].busy;
      drive_and_sample();
      chk($sformatf("vec%0d_wr", i), op_uart_wr, tv[i].ew);
      if (tv[i].ew) chk($sformatf("vec%0d_data", i), op_uart_tx_data, tv[i].ed);
      chk($sformatf("vec%0d_count", i), op_count, tv[i].ec);
      finish_cycle();
    end
    s_wr = 0;

    // burst of 8 with a slow UART
    use_uart = 1; uart_len = 10; ignore_pct = 0; uart_left = 0;
    tx_log.delete(); saw_full = 0;
    for (int i = 1; i <= 8; i++) begin
      s_wr = 1; s_data = 8'(i); step();
    end
    s_wr = 0;
    n = 0;
    while (tx_log.size() < 8 && n < 200) begin step(); n++; end
    chk("burst_n", tx_log.size(), 8);
    for (int k = 0; k < tx_log.size(); k++) chk($sformatf("burst_order%0d", k), tx_log[k], k + 1);
    chk("burst_never_full", saw_full, 0);

    // overflow with busy held high
    use_uart = 0; uart_left = 0; s_busy = 0;
    s_rst = 1; step(); s_rst = 0;
    s_busy = 1;
    for (int i = 0; i < 9; i++) begin
      s_wr = 1; s_data = 8'h10 + 8'(i); step();
    end
    s_wr = 0;
    chk("ovf_count", op_count, 8);
    chk("ovf_full", op_full, 1);
    chk("ovf_flag", op_overflow, 1);
    s_clr = 1; step(); s_clr = 0;
    chk("clr_flag", op_overflow, 0);
    chk("clr_count", op_count, 8);

    // full FIFO: push on the pop cycle is accepted
    tx_log.delete(); use_uart = 1; uart_len = 2; uart_left = 0;
    s_wr = 1; s_data = 8'hAA; step(); s_wr = 0;
    chk("fullpop_count", op_count, 8);
    chk("fullpop_ovf", op_overflow, 0);
    chk("fullpop_full", op_full, 1);
    n = 0;
    while (tx_log.size() < 9 && n < 200) begin step(); n++; end
    for (int k = 0; k < 8; k++) exp_seq[k] = 8'h10 + 8'(k);
    exp_seq[8] = 8'hAA;
    chk("drain_n", tx_log.size(), 9);
    for (int k = 0; k < tx_log.size() && k < 9; k++) chk($sformatf("drain%0d", k), tx_log[k], exp_seq[k]);

    // reset during WAIT_DONE with bytes queued
    use_uart = 0; uart_left = 0; s_busy = 0;
    s_rst = 1; step(); s_rst = 0;
    s_wr = 1; s_data = 8'h61; s_busy = 0; step();
    s_data = 8'h62; step();
    s_data = 8'h63; s_busy = 1; step();
    s_data = 8'h64; step();
    s_data = 8'h65; step();
    s_wr = 0;
    chk("prerst_count", op_count, 4);
    s_rst = 1; step(); s_rst = 0;
    chk("midrst_count", op_count, 0);
    chk("midrst_empty", op_empty, 1);
    tx_log.delete(); s_busy = 0;
    for (int i = 0; i < 20; i++) step();
    chk("postrst_strobes", tx_log.size(), 0);
    chk("postrst_count", op_count, 0);

    // randomized traffic with a lossy UART
    use_uart = 1; ignore_pct = 20; uart_left = 0;
    for (int i = 0; i < 400; i++) begin
      s_wr = ($urandom_range(9) < 6);
      s_data = 8'($urandom);
      s_clr = ($urandom_range(19) == 0);
      s_rst = ($urandom_range(149) == 0);
      uart_len = $urandom_range(1, 5);
      step();
    end
    s_wr = 0; s_clr = 0; s_rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
